// File: rtl/loteria_param.sv
// ---------------------------------------------------------------------------
// loteria_param
//   Lottery ticket checker. Ticket digits arrive one per cycle on numero/insere
//   and are compared, digit 0 first, against a stored draw. When the last digit
//   is accepted, the length of the matching leading prefix selects a prize. The
//   prize code is registered and qualified by a one-cycle premio_valid pulse.
//   Saturating counters keep a tally of completed tickets and of each prize.
//
// Ports
//   clock        : rising-edge clock
//   reset        : synchronous, active-low reset
//   numero       : ticket digit, qualified by insere
//   insere       : digit-valid strobe
//   cancela      : abort the ticket in progress
//   load         : replace the stored draw with sorteio_in (honoured only when idle)
//   sorteio_in   : new draw, digit 0 in the most significant DW bits
//   fim_jogo     : end of game; clears the counters and premio, aborts the ticket
//   premio       : 00 none, 01 prize 1, 10 prize 2, 11 prize 3
//   premio_valid : one-cycle pulse after a ticket completes
//   p1, p2, p3   : number of tickets that earned prize 1, 2 and 3
//   jogos        : number of completed tickets
//   busy         : a ticket is partially entered
// ---------------------------------------------------------------------------
module loteria_param #(
  parameter int                   DIGITS       = 5,
  parameter int                   DW           = 4,
  parameter int                   CW           = 5,
  parameter logic [DIGITS*DW-1:0] SORTEIO_INIT = {4'd5, 4'd3, 4'd8, 4'd2, 4'd0},
  parameter int                   P2_MIN       = 3,
  parameter int                   P3_MIN       = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DW-1:0]        numero,
  input  logic                 insere,
  input  logic                 cancela,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] sorteio_in,
  input  logic                 fim_jogo,
  output logic [1:0]           premio,
  output logic                 premio_valid,
  output logic [CW-1:0]        p1,
  output logic [CW-1:0]        p2,
  output logic [CW-1:0]        p3,
  output logic [CW-1:0]        jogos,
  output logic                 busy
);

  localparam int IW = $clog2(DIGITS);
  localparam int KW = $clog2(DIGITS + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [1:0] PRZ_NONE = 2'b00;
  localparam logic [1:0] PRZ_1    = 2'b01;
  localparam logic [1:0] PRZ_2    = 2'b10;
  localparam logic [1:0] PRZ_3    = 2'b11;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;        // index of the next digit expected
  logic [KW-1:0]          k_q, k_d;            // matching prefix length so far
  logic                   run_q, run_d;        // every digit so far has matched
  logic [DIGITS*DW-1:0]   sorteio_q, sorteio_d;
  logic [1:0]             premio_q, premio_d;
  logic                   premio_valid_q, premio_valid_d;
  logic [CW-1:0]          p1_q, p1_d;
  logic [CW-1:0]          p2_q, p2_d;
  logic [CW-1:0]          p3_q, p3_d;
  logic [CW-1:0]          jogos_q, jogos_d;

  logic [DW-1:0]          draw_digit [DIGITS];
  logic                   accept;
  logic                   complete;
  logic                   run_eff;
  logic                   hit;
  logic [KW-1:0]          k_eff;
  logic [KW-1:0]          k_new;
  logic [1:0]             prize;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Unpack the stored draw; digit 0 lives in the most significant field.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      draw_digit[i] = sorteio_q[(DIGITS-1-i)*DW +: DW];
    end
  end

  // Input decode in priority order: fim_jogo, cancela, load, insere. A digit
  // is accepted only when no higher-priority control is present this cycle.
  always_comb begin
    accept   = insere && !fim_jogo && !cancela && !load;
    complete = accept && (state_q == COLLECT) && (idx_q == LAST_IDX);

    // A ticket starting in IDLE has an empty, still-matching prefix. idx_q is
    // held at 0 whenever the FSM is idle, so it already points at digit 0.
    run_eff = (state_q == IDLE) ? 1'b1 : run_q;
    k_eff   = (state_q == IDLE) ? '0   : k_q;

    // Once a mismatch has been seen, later matching digits do not extend k.
    hit   = run_eff && (numero == draw_digit[idx_q]);
    k_new = k_eff + KW'(hit);

    if (int'(k_new) == DIGITS)      prize = PRZ_1;
    else if (int'(k_new) >= P2_MIN) prize = PRZ_2;
    else if (int'(k_new) >= P3_MIN) prize = PRZ_3;
    else                            prize = PRZ_NONE;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (fim_jogo || cancela) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = complete ? IDLE : COLLECT;
    end
  end

  // Datapath next values.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
    idx_d          = idx_q;
    k_d            = k_q;
    run_d          = run_q;
    sorteio_d      = sorteio_q;
    premio_d       = premio_q;
    premio_valid_d = 1'b0;
    p1_d           = p1_q;
    p2_d           = p2_q;
    p3_d           = p3_q;
    jogos_d        = jogos_q;

    if (fim_jogo) begin
      idx_d    = '0;
      premio_d = PRZ_NONE;
      p1_d     = '0;
      p2_d     = '0;
      p3_d     = '0;
      jogos_d  = '0;
    end else if (cancela) begin
      idx_d = '0;
    end else if (load) begin
      // A draw change mid-ticket would mix two draws in one comparison.
      if (state_q == IDLE) sorteio_d = sorteio_in;
    end else if (accept) begin
      if (complete) begin
        idx_d          = '0;
        premio_d       = prize;
        premio_valid_d = 1'b1;
        jogos_d        = sat_inc(jogos_q);
        case (prize)
          PRZ_1:   p1_d = sat_inc(p1_q);
          PRZ_2:   p2_d = sat_inc(p2_q);
          PRZ_3:   p3_d = sat_inc(p3_q);
          default: ;
        endcase
      end else begin
        idx_d = idx_q + 1'b1;
        k_d   = k_new;
        run_d = hit;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      k_q            <= '0;
      run_q          <= 1'b1;
      sorteio_q      <= SORTEIO_INIT;
      premio_q       <= PRZ_NONE;
      premio_valid_q <= 1'b0;
      p1_q           <= '0;
      p2_q           <= '0;
      p3_q           <= '0;
      jogos_q        <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      k_q            <= k_d;
      run_q          <= run_d;
      sorteio_q      <= sorteio_d;
      premio_q       <= premio_d;
      premio_valid_q <= premio_valid_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      p3_q           <= p3_d;
      jogos_q        <= jogos_d;
    end
  end

  // Outputs.
  always_comb begin
    busy         = (state_q == COLLECT);
    premio       = premio_q;
    premio_valid = premio_valid_q;
    p1           = p1_q;
    p2           = p2_q;
    p3           = p3_q;
    jogos        = jogos_q;
  end

endmodule

// File: tb/tb_loteria_param.sv
// ---------------------------------------------------------------------------
// tb_loteria_param
//   Directed bench for loteria_param. dut_a uses the default parameters;
//   dut_b (CW=2) shares the same stimulus and is used for saturation.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, i.e. they show the result of that edge.
// ---------------------------------------------------------------------------
module tb_loteria_param;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  numero;
  logic        insere;
  logic        cancela;
  logic        load;
  logic [19:0] sorteio_in;
  logic        fim_jogo;

  logic [1:0]  premio_a, premio_b;
  logic        premio_valid_a, premio_valid_b;
  logic [4:0]  p1_a, p2_a, p3_a, jogos_a;
  logic [1:0]  p1_b, p2_b, p3_b, jogos_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;
  int pulses_b = 0;

  always #5 clock = ~clock;

  loteria_param dut_a (
    .clock(clock), .reset(reset), .numero(numero), .insere(insere),
    .cancela(cancela), .load(load), .sorteio_in(sorteio_in), .fim_jogo(fim_jogo),
    .premio(premio_a), .premio_valid(premio_valid_a),
    .p1(p1_a), .p2(p2_a), .p3(p3_a), .jogos(jogos_a), .busy(busy_a)
  );

  loteria_param #(.CW(2)) dut_b (
    .clock(clock), .reset(reset), .numero(numero), .insere(insere),
    .cancela(cancela), .load(load), .sorteio_in(sorteio_in), .fim_jogo(fim_jogo),
    .premio(premio_b), .premio_valid(premio_valid_b),
    .p1(p1_b), .p2(p2_b), .p3(p3_b), .jogos(jogos_b), .busy(busy_b)
  );

  // Counts premio_valid pulses of dut_b; premio_valid is only ever 1 for one cycle.
  always @(posedge clock) if (premio_valid_b) pulses_b++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic digit(input logic [3:0] d);
    numero = d;
    insere = 1'b1;
    tick();
    insere = 1'b0;
  endtask

  task automatic ticket(input logic [3:0] d0, d1, d2, d3, d4);
    digit(d0);
    digit(d1);
    digit(d2);
    digit(d3);
    digit(d4);
  endtask

  initial begin
    reset      = 1'b0;
    numero     = '0;
    insere     = 1'b0;
    cancela    = 1'b0;
    load       = 1'b0;
    sorteio_in = '0;
    fim_jogo   = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_premio", premio_a, 2'b00);
    check("rst_valid", premio_valid_a, 1'b0);
    check("rst_p1", p1_a, 0);
    check("rst_jogos", jogos_a, 0);
    check("rst_busy", busy_a, 1'b0);
    reset = 1'b1;
    tick();

    // Full match 5,3,8,2,0 -> prize 1.
    digit(4'd5);
    digit(4'd3);
    check("busy_mid", busy_a, 1'b1);
    digit(4'd8);
    digit(4'd2);
    digit(4'd0);
    check("t1_valid", premio_valid_a, 1'b1);
    check("t1_premio", premio_a, 2'b01);
    check("t1_p1", p1_a, 1);
    check("t1_jogos", jogos_a, 1);
    check("t1_busy", busy_a, 1'b0);
    tick();
    check("t1_valid_1cyc", premio_valid_a, 1'b0);
    check("t1_premio_hold", premio_a, 2'b01);

    // Prefix 3 -> prize 2.
    ticket(4'd5, 4'd3, 4'd8, 4'd7, 4'd0);
    check("t2_premio", premio_a, 2'b10);
    check("t2_p2", p2_a, 1);
    // Prefix 2, later digits match again but must not extend k -> prize 3.
    ticket(4'd5, 4'd3, 4'd1, 4'd2, 4'd0);
    check("t3_premio", premio_a, 2'b11);
    check("t3_p3", p3_a, 1);
    // First digit wrong -> no prize.
    ticket(4'd1, 4'd3, 4'd8, 4'd2, 4'd0);
    check("t4_valid", premio_valid_a, 1'b1);
    check("t4_premio", premio_a, 2'b00);
    check("t4_jogos", jogos_a, 4);
    check("t4_p1", p1_a, 1);
    check("t4_p2", p2_a, 1);
    check("t4_p3", p3_a, 1);

    // Saturation with CW=2: four winners back to back, no idle cycle.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pulses_b = 0;
    ticket(4'd5, 4'd3, 4'd8, 4'd2, 4'd0);
    digit(4'd5);
    check("b2b_accept_during_valid", busy_b, 1'b1);
    digit(4'd3);
    digit(4'd8);
    digit(4'd2);
    digit(4'd0);
    ticket(4'd5, 4'd3, 4'd8, 4'd2, 4'd0);
    ticket(4'd5, 4'd3, 4'd8, 4'd2, 4'd0);
    tick();
    check("sat_pulses", pulses_b, 4);
    check("sat_p1", p1_b, 3);
    check("sat_jogos", jogos_b, 3);
    check("nosat_p1_a", p1_a, 4);

    // Load in IDLE takes effect for the next ticket.
    sorteio_in = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    load = 1'b1;
    tick();
    load = 1'b0;
    ticket(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    check("load_premio", premio_a, 2'b01);
    check("load_p1", p1_a, 5);
    // Load mid-ticket is ignored; the draw stays 1,1,1,1,1.
    digit(4'd1);
    digit(4'd1);
    sorteio_in = {4'd5, 4'd3, 4'd8, 4'd2, 4'd0};
    load = 1'b1;
    tick();
    load = 1'b0;
    check("load_collect_busy", busy_a, 1'b1);
    digit(4'd1);
    digit(4'd1);
    digit(4'd1);
    check("load_ignored_premio", premio_a, 2'b01);
    check("load_ignored_p1", p1_a, 6);

    // Cancel with a simultaneous insere: ticket dropped, no pulse, no count.
    tick();
    digit(4'd1);
    digit(4'd1);
    digit(4'd1);
    cancela = 1'b1;
    numero  = 4'd1;
    insere  = 1'b1;
    tick();
    cancela = 1'b0;
    insere  = 1'b0;
    check("cancel_busy", busy_a, 1'b0);
    check("cancel_valid", premio_valid_a, 1'b0);
    check("cancel_jogos", jogos_a, 6);

    // fim_jogo after p1=2 clears counters and premio, keeps the draw.
    fim_jogo = 1'b1;
    tick();
    fim_jogo = 1'b0;
    ticket(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    ticket(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    check("pre_fim_p1", p1_a, 2);
    fim_jogo = 1'b1;
    tick();
    fim_jogo = 1'b0;
    check("fim_p1", p1_a, 0);
    check("fim_jogos", jogos_a, 0);
    check("fim_premio", premio_a, 2'b00);
    ticket(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    check("fim_draw_kept", premio_a, 2'b01);

    // fim_jogo on the completion edge wins.
    digit(4'd1);
    digit(4'd1);
    digit(4'd1);
    digit(4'd1);
    fim_jogo = 1'b1;
    digit(4'd1);
    fim_jogo = 1'b0;
    check("fim_cmpl_valid", premio_valid_a, 1'b0);
    check("fim_cmpl_p1", p1_a, 0);
    check("fim_cmpl_jogos", jogos_a, 0);
    check("fim_cmpl_busy", busy_a, 1'b0);

    // Reset mid-ticket discards it and restores the initial draw.
    ticket(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    digit(4'd1);
    digit(4'd1);
    digit(4'd1);
    digit(4'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_premio", premio_a, 2'b00);
    check("mid_rst_valid", premio_valid_a, 1'b0);
    check("mid_rst_p1", p1_a, 0);
    check("mid_rst_jogos", jogos_a, 0);
    ticket(4'd5, 4'd3, 4'd8, 4'd2, 4'd0);
    check("post_rst_p1", p1_a, 1);
    check("post_rst_jogos", jogos_a, 1);
    check("post_rst_premio", premio_a, 2'b01);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
